adc_spi_sequencer: RTL and testbench
====================================

Name: adc_spi_sequencer

Overview:
- Serial-configuration sequencer for the twelve front-end ADCs: six groups, two chip selects each.
- Drives the logical, active-high ADC_CS[11:0], ADC_RST, ADC_SCLK and ADC_SDATA nets that the ADC output-buffer block inverts as needed and pads out.
- Accepts single 24-bit register writes (8-bit address + 16-bit data, MSB first) broadcast to any subset of ADCs, plus a timed ADC hardware-reset request.
- Sits between the slow-control register decoder and the ADC output buffers.

Parameters:
HALF_PER, 4, SCLK half-period in CLK cycles (>=2).
RST_CYCLES, 16, ADC_RST pulse width in CLK cycles (>=1).
RST_WAIT, 64, post-reset settle time in CLK cycles before DONE (>=1).

Ports:
CLK  input  1  system clock; all logic on rising edge.
RST  input  1  asynchronous, active-high reset.
WR_REQ  input  1  single-cycle write request; sampled only when BUSY=0.
WR_MASK  input  12  ADC select; bit i drives ADC_CS[i].
WR_ADDR  input  8  ADC register address (frame bits 23:16).
WR_DATA  input  16  ADC register data (frame bits 15:0).
RST_REQ  input  1  single-cycle ADC hardware-reset request; sampled only when BUSY=0.
BUSY  output  1  high from the cycle after acceptance until the DONE cycle inclusive.
DONE  output  1  one-cycle completion pulse.
ADC_CS  output  12  active-high chip selects (logical polarity).
ADC_RST  output  1  active-high ADC reset (logical polarity).
ADC_SCLK  output  1  serial clock; idles low.
ADC_SDATA  output  1  serial data; idles low.

Behaviour:
- All outputs are registered, with no combinational path from inputs to outputs.
- Reset values: BUSY=0, DONE=0, ADC_CS=0, ADC_RST=0, ADC_SCLK=0, ADC_SDATA=0, state=IDLE.
- Asserting RST mid-operation forces these values immediately. It aborts any frame or reset pulse with no completion DONE.
- States: IDLE, CS_SETUP, SHIFT_HI, SHIFT_LO, GAP, RST_PULSE, RST_SETTLE.
- IDLE:
  - RST_REQ takes priority over WR_REQ when both are asserted in the same cycle. The write is then dropped.
  - Requests arriving while BUSY=1 are ignored, not queued.
- Write accepted in cycle N with WR_MASK!=0:
  - The frame {WR_ADDR, WR_DATA} and WR_MASK are captured.
  - Cycle N+1: BUSY=1, ADC_CS=mask, ADC_SDATA=frame[23], SCLK=0. CS_SETUP lasts HALF_PER cycles.
  - For each bit k=23..0: SHIFT_HI lasts HALF_PER cycles with SCLK=1 and SDATA=frame[k] held stable. SHIFT_LO then lasts HALF_PER cycles with SCLK=0.
  - At entry to SHIFT_LO, SDATA changes to frame[k-1]. After bit 0 it changes to 0.
  - The ADC samples on the SCLK rising edge, so SDATA changes only on the falling edge. This gives setup/hold of HALF_PER cycles.
  - The SHIFT_LO phase after bit 0 is the CS hold time. ADC_CS therefore stays at the mask for exactly 49*HALF_PER cycles.
  - There are exactly 24 SCLK rising edges per frame.
  - GAP: ADC_CS=0 for HALF_PER cycles. DONE pulses in the last GAP cycle, with BUSY=1 in that cycle and BUSY=0 in the next.
  - Total: DONE occurs at cycle N+50*HALF_PER.
- Write accepted with WR_MASK=0: no CS, SCLK or SDATA activity. BUSY=1 and DONE=1 in cycle N+1, then IDLE.
- Reset request accepted in cycle N:
  - RST_PULSE: ADC_RST=1 for cycles N+1..N+RST_CYCLES. ADC_CS=0 and SCLK=0 throughout.
  - RST_SETTLE: ADC_RST=0 for RST_WAIT cycles. DONE pulses in the last settle cycle, at N+RST_CYCLES+RST_WAIT.
- Counters are sized to hold max(HALF_PER, RST_CYCLES, RST_WAIT). The bit counter is 5 bits and terminates at 0, with no wrap-around.
- DONE is never asserted together with a new acceptance. The earliest next acceptance is the cycle after DONE.

Test Plan:
- Reset, then idle 10 cycles -> all outputs 0, BUSY=0.
- WR_REQ at N, WR_MASK=12'h003, ADDR=8'h46, DATA=16'h8801, HALF_PER=4 -> ADC_CS=003 for cycles N+1..N+196. Exactly 24 SCLK rises. Bits sampled at the rises = 24'h468801, MSB first. DONE at N+200. BUSY low at N+201.
- RST_REQ and WR_REQ both asserted at cycle N -> ADC_RST=1 for 16 cycles (N+1..N+16), DONE at N+80, no SCLK edges; the write is never executed.
- WR_MASK=0 write at N -> DONE at N+1, ADC_CS/SCLK/SDATA stay 0.
- Second WR_REQ issued 20 cycles into an active frame -> ignored: only one DONE, and the frame contents are unchanged.
- Assert RST at the 10th SCLK rise -> same cycle all outputs 0. No DONE. A fresh write issued after RST release completes normally in 50*HALF_PER cycles.

Source files
------------

// File: rtl/adc_spi_sequencer.sv
// adc_spi_sequencer: serial-configuration sequencer for the twelve front-end ADCs.
// Issues 24-bit register writes ({addr, data}, MSB first) to any subset of chip
// selects, and produces timed ADC hardware-reset pulses. All outputs are registered.
module adc_spi_sequencer #(
    parameter int unsigned HALF_PER   = 4,
    parameter int unsigned RST_CYCLES = 16,
    parameter int unsigned RST_WAIT   = 64
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        WR_REQ,
    input  logic [11:0] WR_MASK,
    input  logic [7:0]  WR_ADDR,
    input  logic [15:0] WR_DATA,
    input  logic        RST_REQ,
    output logic        BUSY,
    output logic        DONE,
    output logic [11:0] ADC_CS,
    output logic        ADC_RST,
    output logic        ADC_SCLK,
    output logic        ADC_SDATA
);

    localparam int unsigned MAX_A = (HALF_PER > RST_CYCLES) ? HALF_PER : RST_CYCLES;
    localparam int unsigned MAX_C = (MAX_A > RST_WAIT) ? MAX_A : RST_WAIT;
    localparam int unsigned CW    = (MAX_C < 2) ? 1 : $clog2(MAX_C + 1);

    localparam logic [CW-1:0] HP_LOAD  = CW'(HALF_PER - 1);
    localparam logic [CW-1:0] RC_LOAD  = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] RW_LOAD  = CW'(RST_WAIT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic          RW_SHORT = (RST_WAIT == 1);

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        SHIFT_HI,
        SHIFT_LO,
        GAP,
        RST_PULSE,
        RST_SETTLE
    } state_t;

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]  bit_q, bit_d;
    logic [23:0] frame_q, frame_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [11:0] cs_q, cs_d;
    logic        adcrst_q, adcrst_d;
    logic        sclk_q, sclk_d;
    logic        sdata_q, sdata_d;
    logic [4:0]  nxt_bit;

    assign nxt_bit = bit_q - 5'd1;

    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign ADC_CS    = cs_q;
    assign ADC_RST   = adcrst_q;
    assign ADC_SCLK  = sclk_q;
    assign ADC_SDATA = sdata_q;

    // State, counters, captured frame and registered outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            frame_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cs_q     <= '0;
            adcrst_q <= 1'b0;
            sclk_q   <= 1'b0;
            sdata_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            frame_q  <= frame_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            cs_q     <= cs_d;
            adcrst_q <= adcrst_d;
            sclk_q   <= sclk_d;
            sdata_q  <= sdata_d;
        end
    end

    // Next-state and next-output decode; outputs are computed one cycle ahead
    // so that every pin comes straight from a flop.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        frame_d  = frame_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        cs_d     = cs_q;
        adcrst_d = adcrst_q;
        sclk_d   = sclk_q;
        sdata_d  = sdata_q;

        case (state_q)
            IDLE: begin
                busy_d   = 1'b0;
                cs_d     = '0;
                adcrst_d = 1'b0;
                sclk_d   = 1'b0;
                sdata_d  = 1'b0;
                // busy_q can be high here only in the DONE cycle of a
                // zero-mask write; requests are ignored in that cycle.
                if (!busy_q) begin
                    if (RST_REQ) begin
                        state_d  = RST_PULSE;
                        cnt_d    = RC_LOAD;
                        busy_d   = 1'b1;
                        adcrst_d = 1'b1;
                    end else if (WR_REQ) begin
                        busy_d = 1'b1;
                        if (WR_MASK == 12'd0) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = CS_SETUP;
                            cnt_d   = HP_LOAD;
                            bit_d   = 5'd23;
                            frame_d = {WR_ADDR, WR_DATA};
                            cs_d    = WR_MASK;
                            sdata_d = WR_ADDR[7];
                        end
                    end
                end
            end

            CS_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = SHIFT_HI;
                    cnt_d   = HP_LOAD;
                    sclk_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            SHIFT_HI: begin
                if (cnt_q == '0) begin
                    state_d = SHIFT_LO;
                    cnt_d   = HP_LOAD;
                    sclk_d  = 1'b0;
                    sdata_d = (bit_q == 5'd0) ? 1'b0 : frame_q[nxt_bit];
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            SHIFT_LO: begin
                if (cnt_q == '0) begin
                    cnt_d = HP_LOAD;
                    if (bit_q == 5'd0) begin
                        state_d = GAP;
                        cs_d    = '0;
                    end else begin
                        state_d = SHIFT_HI;
                        bit_d   = nxt_bit;
                        sclk_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            GAP: begin
                // HALF_PER >= 2, so the cycle with cnt_q == 1 always exists.
                done_d = (cnt_q == CNT_ONE);
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            RST_PULSE: begin
                if (cnt_q == '0) begin
                    state_d  = RST_SETTLE;
                    cnt_d    = RW_LOAD;
                    adcrst_d = 1'b0;
                    done_d   = RW_SHORT;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            RST_SETTLE: begin
                done_d = (cnt_q == CNT_ONE);
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            default: begin
                state_d  = IDLE;
                busy_d   = 1'b0;
                cs_d     = '0;
                adcrst_d = 1'b0;
                sclk_d   = 1'b0;
                sdata_d  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_adc_spi_sequencer.sv
// Self-checking bench for adc_spi_sequencer: directed scenarios plus randomized
// writes/reset requests, judged against frame-level expectations (bit stream,
// edge counts, durations, completion latency).
module tb_adc_spi_sequencer;

    localparam int HP = 4;
    localparam int RC = 16;
    localparam int RW = 64;

    logic        CLK = 1'b0;
    logic        RST;
    logic        WR_REQ;
    logic [11:0] WR_MASK;
    logic [7:0]  WR_ADDR;
    logic [15:0] WR_DATA;
    logic        RST_REQ;
    logic        BUSY;
    logic        DONE;
    logic [11:0] ADC_CS;
    logic        ADC_RST;
    logic        ADC_SCLK;
    logic        ADC_SDATA;

    int total = 0;
    int bad   = 0;

    adc_spi_sequencer #(
        .HALF_PER  (HP),
        .RST_CYCLES(RC),
        .RST_WAIT  (RW)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .WR_REQ   (WR_REQ),
        .WR_MASK  (WR_MASK),
        .WR_ADDR  (WR_ADDR),
        .WR_DATA  (WR_DATA),
        .RST_REQ  (RST_REQ),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .ADC_CS   (ADC_CS),
        .ADC_RST  (ADC_RST),
        .ADC_SCLK (ADC_SCLK),
        .ADC_SDATA(ADC_SDATA)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // One write: the frame must carry {a,d} MSB first on 24 rising edges,
    // CS held at the mask for 49*HP cycles, DONE at 50*HP (or 1 if mask is 0).
    task automatic run_write(input logic [11:0] m, input logic [7:0] a,
                             input logic [15:0] d, input bit inject, input int abort_rise);
        int t, budget, exp_done, rises, hi_cyc, cs_cyc, cs_bad, idle_bad, sd_bad;
        int busy_bad, done_n, done_t, post_done;
        logic [23:0] word;
        logic ps, psd;
        logic [11:0] pcs;
        bit aborted;
        exp_done = (m == 12'd0) ? 1 : 50 * HP;
        budget = 50 * HP + 40;
        rises = 0; hi_cyc = 0; cs_cyc = 0; cs_bad = 0; idle_bad = 0; sd_bad = 0;
        busy_bad = 0; done_n = 0; done_t = -1; post_done = 0;
        word = '0; ps = 1'b0; psd = 1'b0; pcs = '0; aborted = 1'b0;
        WR_REQ = 1'b1; WR_MASK = m; WR_ADDR = a; WR_DATA = d;
        step();
        WR_REQ = 1'b0;
        for (t = 1; t <= budget; t++) begin
            if (inject) begin
                WR_REQ = (t == 20);
                if (t == 20) begin
                    WR_MASK = 12'hFFF; WR_ADDR = ~a; WR_DATA = ~d;
                end
            end
            if (ADC_SCLK && !ps) begin
                rises++;
                word = {word[22:0], ADC_SDATA};
            end
            if (ADC_SCLK) hi_cyc++;
            if (ADC_CS != 12'd0) begin
                cs_cyc++;
                if (ADC_CS != m) cs_bad++;
            end else if (ADC_SCLK || ADC_SDATA) begin
                idle_bad++;
            end
            if (ADC_RST) idle_bad++;
            if (ADC_SDATA !== psd && !(ps && !ADC_SCLK) && !(pcs == 12'd0 && ADC_CS != 12'd0))
                sd_bad++;
            if (done_t < 0 && !BUSY) busy_bad++;
            if (DONE) begin
                done_n++;
                if (done_t < 0) done_t = t;
            end
            if (done_t > 0 && t == done_t + 1) begin
                chk("busy_after_done", {31'd0, BUSY}, 32'd0);
                post_done = 1;
            end
            if (abort_rise > 0 && rises == abort_rise) begin
                RST = 1'b1;
                #1;
                chk("abort_outputs_zero", {15'd0, BUSY, DONE, ADC_CS, ADC_RST, ADC_SCLK, ADC_SDATA}, 32'd0);
                aborted = 1'b1;
                break;
            end
            ps = ADC_SCLK; psd = ADC_SDATA; pcs = ADC_CS;
            step();
        end
        WR_REQ = 1'b0;
        if (aborted) begin
            step();
            step();
            RST = 1'b0;
            done_n = 0; busy_bad = 0;
            for (int k = 0; k < 60; k++) begin
                step();
                if (DONE) done_n++;
                if (BUSY || ADC_CS != 12'd0 || ADC_SCLK) busy_bad++;
            end
            chk("abort_no_done", done_n, 32'd0);
            chk("abort_stays_idle", busy_bad, 32'd0);
        end else begin
            chk("done_latency", done_t, exp_done);
            chk("done_count", done_n, 32'd1);
            chk("busy_window", busy_bad, 32'd0);
            chk("busy_after_seen", post_done, 32'd1);
            chk("idle_lines_quiet", idle_bad, 32'd0);
            chk("sdata_changes_on_fall", sd_bad, 32'd0);
            if (m != 12'd0) begin
                chk("sclk_rises", rises, 32'd24);
                chk("frame_bits", {8'd0, word}, {8'd0, a, d});
                chk("sclk_high_cycles", hi_cyc, 24 * HP);
                chk("cs_cycles", cs_cyc, 49 * HP);
                chk("cs_value", cs_bad, 32'd0);
            end else begin
                chk("mask0_no_sclk", rises, 32'd0);
                chk("mask0_no_cs", cs_cyc, 32'd0);
            end
        end
    endtask

    // ADC hardware reset: ADC_RST high for cycles 1..RC after acceptance,
    // DONE at RC+RW, no serial activity (a simultaneous write is dropped).
    task automatic run_rst(input bit with_wr);
        int t, first, last, cnt, rises, cs_cyc, done_t, done_n, busy_bad, post_done;
        logic ps;
        first = -1; last = -1; cnt = 0; rises = 0; cs_cyc = 0; done_t = -1;
        done_n = 0; busy_bad = 0; post_done = 0; ps = 1'b0;
        RST_REQ = 1'b1;
        WR_REQ = with_wr;
        WR_MASK = 12'($urandom_range(1, 4095));
        WR_ADDR = 8'($urandom);
        WR_DATA = 16'($urandom);
        step();
        RST_REQ = 1'b0;
        WR_REQ = 1'b0;
        for (t = 1; t <= RC + RW + 60; t++) begin
            if (ADC_RST) begin
                cnt++;
                if (first < 0) first = t;
                last = t;
            end
            if (ADC_SCLK && !ps) rises++;
            if (ADC_CS != 12'd0) cs_cyc++;
            if (done_t < 0 && !BUSY) busy_bad++;
            if (DONE) begin
                done_n++;
                if (done_t < 0) done_t = t;
            end
            if (done_t > 0 && t == done_t + 1) begin
                chk("rst_busy_after_done", {31'd0, BUSY}, 32'd0);
                post_done = 1;
            end
            ps = ADC_SCLK;
            step();
        end
        chk("rst_pulse_first", first, 32'd1);
        chk("rst_pulse_last", last, RC);
        chk("rst_pulse_len", cnt, RC);
        chk("rst_done_latency", done_t, RC + RW);
        chk("rst_done_count", done_n, 32'd1);
        chk("rst_busy_window", busy_bad, 32'd0);
        chk("rst_busy_after_seen", post_done, 32'd1);
        chk("rst_no_sclk", rises, 32'd0);
        chk("rst_no_cs", cs_cyc, 32'd0);
    endtask

    initial begin
        int nz;
        RST = 1'b1; WR_REQ = 1'b0; WR_MASK = '0; WR_ADDR = '0; WR_DATA = '0; RST_REQ = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_outputs", {15'd0, BUSY, DONE, ADC_CS, ADC_RST, ADC_SCLK, ADC_SDATA}, 32'd0);
        RST = 1'b0;
        nz = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if ({BUSY, DONE, ADC_CS, ADC_RST, ADC_SCLK, ADC_SDATA} != 17'd0) nz++;
        end
        chk("idle_after_reset", nz, 32'd0);

        run_write(12'h003, 8'h46, 16'h8801, 1'b0, 0);
        run_rst(1'b1);
        run_write(12'h000, 8'hA5, 16'h5A5A, 1'b0, 0);
        run_write(12'h840, 8'h3C, 16'hC3F0, 1'b1, 0);
        run_write(12'hFFF, 8'h99, 16'h1234, 1'b0, 10);
        run_write(12'h801, 8'hFF, 16'h0001, 1'b0, 0);

        for (int n = 0; n < 10; n++) begin
            int op;
            op = int'($urandom_range(0, 9));
            repeat ($urandom_range(0, 3)) step();
            if (op < 2) run_rst(1'b0);
            else if (op == 2) run_write(12'h000, 8'($urandom), 16'($urandom), 1'b0, 0);
            else run_write(12'($urandom_range(1, 4095)), 8'($urandom), 16'($urandom),
                           op[0], 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
